// File: rtl/cpu_ctl_pkg.sv
// Shared types for the multi-cycle main control unit:
// opcodes, state encodings, select codes and the control word.
package cpu_ctl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_word_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in,
// datapath enables, ALU selects and status out.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALU_op;
    logic [1:0]       PCSource;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  Opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        output IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
        output ALUSrcB, ALU_op, PCSource, illegal_op, instr_count
    );

    modport slave (
        output Opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        input  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
        input  ALUSrcB, ALU_op, PCSource, illegal_op, instr_count
    );
endinterface

// File: rtl/mc_out_decode.sv
// Control word decoder: Moore outputs from state, with the IR and
// PC load in FETCH gated by the memory handshake.
module mc_out_decode
    import cpu_ctl_pkg::*;
(
    input  state_e    state,
    input  logic      mem_ready,
    output ctl_word_t ctl
);

    // Per-state control word; anything not set stays 0.
    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                ctl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_B;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: state register, opcode sequencing,
// sticky illegal-opcode flag and retired-instruction counter.
module multicycle_control
    import cpu_ctl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state;
    logic             illegal;
    logic [CNT_W-1:0] count;
    ctl_word_t        ctl;

    mc_out_decode u_dec (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .ctl       (ctl)
    );

    // State sequencing, sticky illegal flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_INIT;
            illegal <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.Opcode)
                        OP_RTYPE:     state <= S_R_EXEC;
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= S_ADDI_EXEC;
                        default: begin
                            state   <= S_ILLEGAL;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR:
                    state <= (bus.Opcode == OP_SW) ? S_MEM_WRITE
                                                   : S_MEM_READ;
                S_MEM_READ: if (bus.mem_ready) state <= S_MEM_WB;
                S_MEM_WRITE: begin
                    if (bus.mem_ready) begin
                        state <= S_FETCH;
                        count <= count + ONE;
                    end
                end
                S_R_EXEC:    state <= S_R_WB;
                S_ADDI_EXEC: state <= S_ADDI_WB;
                S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                    state <= S_FETCH;
                    count <= count + ONE;
                end
                S_ILLEGAL: state <= S_ILLEGAL;
                default:   state <= S_INIT;
            endcase
        end
    end

    assign bus.PCWrite     = ctl.pc_write;
    assign bus.PCWriteCond = ctl.pc_write_cond;
    assign bus.IorD        = ctl.iord;
    assign bus.MemRead     = ctl.mem_read;
    assign bus.MemWrite    = ctl.mem_write;
    assign bus.IRWrite     = ctl.ir_write;
    assign bus.MemtoReg    = ctl.mem_to_reg;
    assign bus.RegDst      = ctl.reg_dst;
    assign bus.RegWrite    = ctl.reg_write;
    assign bus.ALUSrcA     = ctl.alu_src_a;
    assign bus.ALUSrcB     = ctl.alu_src_b;
    assign bus.ALU_op      = ctl.alu_op;
    assign bus.PCSource    = ctl.pc_source;
    assign bus.illegal_op  = illegal;
    assign bus.instr_count = count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control
// words and retire counts queued at drive time, checked at negedge.
module tb_multicycle_control;

    typedef enum int {
        T_INIT, T_FETCH, T_DECODE, T_MADDR, T_MREAD, T_MWB, T_MWRITE,
        T_REXEC, T_RWB, T_AEXEC, T_AWB, T_BR, T_JMP, T_ILL
    } tst_e;

    typedef struct {
        string       tag;
        logic [17:0] word;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fails = 0;
    logic [31:0] exp_cnt = '0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Observed word order:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    // RegDst RegWrite ALUSrcA ALUSrcB[2] ALU_op[2] PCSource[2] illegal
    function automatic logic [17:0] observed();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALU_op,
                bus.PCSource, bus.illegal_op};
    endfunction

    function automatic logic [17:0] model(tst_e s, logic mr);
        logic pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
        logic [1:0] sb_, aop, psrc;
        {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, ill} = '0;
        sb_ = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            T_FETCH:  begin mrd = 1; sb_ = 2'b01; irw = mr; pcw = mr; end
            T_DECODE: sb_ = 2'b11;
            T_MADDR:  begin sa = 1; sb_ = 2'b10; end
            T_MREAD:  begin mrd = 1; iod = 1; end
            T_MWB:    begin rw = 1; m2r = 1; end
            T_MWRITE: begin mwr = 1; iod = 1; end
            T_REXEC:  begin sa = 1; aop = 2'b10; end
            T_RWB:    begin rw = 1; rdst = 1; end
            T_AEXEC:  begin sa = 1; sb_ = 2'b10; end
            T_AWB:    rw = 1;
            T_BR:     begin sa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
            T_JMP:    begin pcw = 1; psrc = 2'b10; end
            T_ILL:    ill = 1;
            default:  ;
        endcase
        return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, sa,
                sb_, aop, psrc, ill};
    endfunction

    // One clock in expected state s with the given inputs.
    task automatic cyc(input string tag, input tst_e s,
                       input logic mr, input logic [5:0] op);
        exp_t e;
        exp_t g;
        bus.mem_ready = mr;
        bus.Opcode = op;
        e.tag = tag;
        e.word = model(s, mr);
        e.cnt = exp_cnt;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        n_checks++;
        assert (observed() === g.word) else begin
            n_fails++;
            $error("FAIL %s ctl got %b want %b", g.tag, observed(), g.word);
        end
        n_checks++;
        assert (bus.instr_count === g.cnt) else begin
            n_fails++;
            $error("FAIL %s cnt got %0d want %0d", g.tag,
                   bus.instr_count, g.cnt);
        end
        @(posedge clk);
        if (s inside {T_MWB, T_RWB, T_AWB, T_BR, T_JMP} ||
            (s == T_MWRITE && mr))
            exp_cnt = exp_cnt + 1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        bus.mem_ready = 1'b1;
        bus.Opcode = 6'h00;
        do_reset();
        cyc("init", T_INIT, 1, 6'h00);

        // R-type
        cyc("r_fetch", T_FETCH, 1, 6'h00);
        cyc("r_dec", T_DECODE, 1, 6'h00);
        cyc("r_exec", T_REXEC, 1, 6'h00);
        cyc("r_wb", T_RWB, 1, 6'h00);

        // lw with three wait cycles in MEM_READ
        cyc("lw_fetch", T_FETCH, 1, 6'h23);
        cyc("lw_dec", T_DECODE, 1, 6'h23);
        cyc("lw_addr", T_MADDR, 1, 6'h23);
        for (int i = 0; i < 3; i++) cyc("lw_wait", T_MREAD, 0, 6'h23);
        cyc("lw_read", T_MREAD, 1, 6'h23);
        cyc("lw_wb", T_MWB, 1, 6'h23);

        // FETCH stall, then sw
        cyc("st_fetch0", T_FETCH, 0, 6'h2b);
        cyc("st_fetch1", T_FETCH, 0, 6'h2b);
        cyc("sw_fetch", T_FETCH, 1, 6'h2b);
        cyc("sw_dec", T_DECODE, 1, 6'h2b);
        cyc("sw_addr", T_MADDR, 1, 6'h2b);
        cyc("sw_write", T_MWRITE, 1, 6'h2b);

        // beq, j, addi
        cyc("beq_fetch", T_FETCH, 1, 6'h04);
        cyc("beq_dec", T_DECODE, 1, 6'h04);
        cyc("beq_br", T_BR, 1, 6'h04);
        cyc("j_fetch", T_FETCH, 1, 6'h02);
        cyc("j_dec", T_DECODE, 1, 6'h02);
        cyc("j_jmp", T_JMP, 1, 6'h02);
        cyc("ai_fetch", T_FETCH, 1, 6'h08);
        cyc("ai_dec", T_DECODE, 1, 6'h08);
        cyc("ai_exec", T_AEXEC, 1, 6'h08);
        cyc("ai_wb", T_AWB, 1, 6'h08);
        cyc("after_mix", T_FETCH, 1, 6'h23);

        // Reset in the middle of a MEM_READ wait
        cyc("rl_dec", T_DECODE, 1, 6'h23);
        cyc("rl_addr", T_MADDR, 0, 6'h23);
        cyc("rl_wait", T_MREAD, 0, 6'h23);
        do_reset();
        cyc("rst_init", T_INIT, 0, 6'h23);
        cyc("rst_fetch", T_FETCH, 0, 6'h23);

        // Illegal opcode
        cyc("il_fetch", T_FETCH, 1, 6'h3f);
        cyc("il_dec", T_DECODE, 1, 6'h3f);
        for (int i = 0; i < 10; i++) cyc("il_hold", T_ILL, 1, 6'h00);
        do_reset();
        cyc("il_clr", T_INIT, 1, 6'h00);
        cyc("il_fetch2", T_FETCH, 1, 6'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
